// File: rtl/rx_ack_decide_if.sv
// rtl/rx_ack_decide_if.sv - ACK request handshake between the ACK decision logic and TX/CSMA
interface rx_ack_decide_if;
  logic        ack_valid;
  logic        ack_ready;
  logic [47:0] ack_addr;
  logic [15:0] ack_duration;

  modport master (
    output ack_valid,
    output ack_addr,
    output ack_duration,
    input  ack_ready
  );

  modport slave (
    input  ack_valid,
    input  ack_addr,
    input  ack_duration,
    output ack_ready
  );
endinterface

// File: rtl/rx_ack_decide.sv
// rtl/rx_ack_decide.sv - decides whether a received PSDU needs an ACK and issues one ACK request
module rx_ack_decide #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000,
  parameter logic [15:0] DUR_SUB        = 16'd44
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [47:0]          self_mac_addr,
  input  logic                 ack_disable,
  input  logic                 pkt_start,
  input  logic [31:0]          FC_DI,
  input  logic                 FC_DI_valid,
  input  logic [47:0]          rx_addr,
  input  logic                 rx_addr_valid,
  input  logic [47:0]          tx_addr,
  input  logic                 tx_addr_valid,
  input  logic                 fcs_in_strobe,
  input  logic                 fcs_ok,
  rx_ack_decide_if.master      ack,
  output logic                 addr_match,
  output logic                 is_broadcast,
  output logic                 ack_abort,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_FC  = 3'd1,
    S_WAIT_RA  = 3'd2,
    S_WAIT_TA  = 3'd3,
    S_WAIT_FCS = 3'd4,
    S_ACK_REQ  = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [15:0] di_q;
  logic        more_frag_q;
  logic [1:0]  type_q;
  logic        ack_valid_q;
  logic [47:0] ack_addr_q;
  logic [15:0] ack_duration_q;
  logic        addr_match_q;
  logic        is_broadcast_q;
  logic        ack_abort_q;

  logic        tmo_hit;
  logic        ra_match;
  logic        ra_bcast;
  logic        eligible;
  logic [15:0] dur_calc;
  logic        unused_fc_bits;

  assign tmo_hit  = (tmo_cnt == (TIMEOUT_CYCLES - 16'd1));
  assign ra_match = (rx_addr == self_mac_addr);
  assign ra_bcast = (rx_addr == 48'hFFFF_FFFF_FFFF);
  // Only management (0) and data (2) frames are acknowledged; control frames never are.
  assign eligible = ((type_q == 2'd0) || (type_q == 2'd2)) && ra_match && !ra_bcast && !ack_disable;

  // AID/reserved encodings and final fragments carry no NAV into the ACK.
  always_comb begin
    dur_calc = 16'd0;
    if (!di_q[15] && more_frag_q && (di_q > DUR_SUB))
      dur_calc = di_q - DUR_SUB;
  end

  assign unused_fc_bits = ^{FC_DI[15:11], FC_DI[9:4], FC_DI[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      tmo_cnt        <= 16'd0;
      di_q           <= 16'd0;
      more_frag_q    <= 1'b0;
      type_q         <= 2'd0;
      ack_valid_q    <= 1'b0;
      ack_addr_q     <= 48'd0;
      ack_duration_q <= 16'd0;
      addr_match_q   <= 1'b0;
      is_broadcast_q <= 1'b0;
      ack_abort_q    <= 1'b0;
    end else begin
      ack_abort_q <= 1'b0;
      if (pkt_start) begin
        // Reaching WAIT_FCS implies the frame was eligible, so the ACK is armed there.
        if ((state == S_ACK_REQ) || (state == S_WAIT_FCS))
          ack_abort_q <= 1'b1;
        state          <= S_WAIT_FC;
        tmo_cnt        <= 16'd0;
        addr_match_q   <= 1'b0;
        is_broadcast_q <= 1'b0;
        ack_valid_q    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            tmo_cnt <= 16'd0;
          end
          S_WAIT_FC: begin
            if (FC_DI_valid) begin
              di_q        <= FC_DI[31:16];
              more_frag_q <= FC_DI[10];
              type_q      <= FC_DI[3:2];
              state       <= S_WAIT_RA;
              tmo_cnt     <= 16'd0;
            end else if (tmo_hit) begin
              state   <= S_IDLE;
              tmo_cnt <= 16'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          S_WAIT_RA: begin
            if (rx_addr_valid) begin
              addr_match_q   <= ra_match;
              is_broadcast_q <= ra_bcast;
              state          <= eligible ? S_WAIT_TA : S_IDLE;
              tmo_cnt        <= 16'd0;
            end else if (tmo_hit) begin
              state   <= S_IDLE;
              tmo_cnt <= 16'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          S_WAIT_TA: begin
            if (tx_addr_valid) begin
              ack_addr_q <= tx_addr;
              state      <= S_WAIT_FCS;
              tmo_cnt    <= 16'd0;
            end else if (tmo_hit) begin
              state   <= S_IDLE;
              tmo_cnt <= 16'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          S_WAIT_FCS: begin
            if (fcs_in_strobe) begin
              tmo_cnt <= 16'd0;
              if (fcs_ok) begin
                state          <= S_ACK_REQ;
                ack_valid_q    <= 1'b1;
                ack_duration_q <= dur_calc;
              end else begin
                state <= S_IDLE;
              end
            end else if (tmo_hit) begin
              state       <= S_IDLE;
              tmo_cnt     <= 16'd0;
              ack_abort_q <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          S_ACK_REQ: begin
            tmo_cnt <= 16'd0;
            if (ack_valid_q && ack.ack_ready) begin
              ack_valid_q <= 1'b0;
              state       <= S_IDLE;
            end
          end
          default: begin
            state   <= S_IDLE;
            tmo_cnt <= 16'd0;
          end
        endcase
      end
    end
  end

  assign ack.ack_valid    = ack_valid_q;
  assign ack.ack_addr     = ack_addr_q;
  assign ack.ack_duration = ack_duration_q;
  assign addr_match       = addr_match_q;
  assign is_broadcast     = is_broadcast_q;
  assign ack_abort        = ack_abort_q;
  assign fsm_state        = state;

endmodule

// File: tb/tb_rx_ack_decide.sv
// tb/tb_rx_ack_decide.sv - directed table-driven bench for rx_ack_decide
module tb_rx_ack_decide;

  localparam logic [47:0] SELF  = 48'h0A1B_2C3D_4E5F;
  localparam logic [47:0] OTHER = 48'h0A1B_2C3D_4E5E;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] A1    = 48'h1122_3344_5566;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] self_mac_addr = SELF;
  logic        ack_disable = 1'b0;
  logic        pkt_start = 1'b0;
  logic [31:0] FC_DI = 32'd0;
  logic        FC_DI_valid = 1'b0;
  logic [47:0] rx_addr = 48'd0;
  logic        rx_addr_valid = 1'b0;
  logic [47:0] tx_addr = 48'd0;
  logic        tx_addr_valid = 1'b0;
  logic        fcs_in_strobe = 1'b0;
  logic        fcs_ok = 1'b0;
  logic        addr_match;
  logic        is_broadcast;
  logic        ack_abort;
  logic [2:0]  fsm_state;

  rx_ack_decide_if ack_if ();

  rx_ack_decide #(.TIMEOUT_CYCLES(16'd8), .DUR_SUB(16'd44)) dut (
    .clk           (clk),
    .rst           (rst),
    .self_mac_addr (self_mac_addr),
    .ack_disable   (ack_disable),
    .pkt_start     (pkt_start),
    .FC_DI         (FC_DI),
    .FC_DI_valid   (FC_DI_valid),
    .rx_addr       (rx_addr),
    .rx_addr_valid (rx_addr_valid),
    .tx_addr       (tx_addr),
    .tx_addr_valid (tx_addr_valid),
    .fcs_in_strobe (fcs_in_strobe),
    .fcs_ok        (fcs_ok),
    .ack           (ack_if.master),
    .addr_match    (addr_match),
    .is_broadcast  (is_broadcast),
    .ack_abort     (ack_abort),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] fc;
    logic [15:0] di;
    logic [47:0] ra;
    logic        ok;
    logic        dis;
    logic        exp_elig;
    logic        exp_ack;
    logic [15:0] exp_dur;
    logic        exp_match;
    logic        exp_bc;
  } vec_t;

  vec_t vecs[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    pkt_start = 1'b1; step(); pkt_start = 1'b0;
  endtask

  task automatic send_fc(input logic [15:0] fc, input logic [15:0] di);
    FC_DI = {di, fc}; FC_DI_valid = 1'b1; step(); FC_DI_valid = 1'b0;
  endtask

  task automatic send_ra(input logic [47:0] ra);
    rx_addr = ra; rx_addr_valid = 1'b1; step(); rx_addr_valid = 1'b0;
  endtask

  task automatic send_ta(input logic [47:0] ta);
    tx_addr = ta; tx_addr_valid = 1'b1; step(); tx_addr_valid = 1'b0;
  endtask

  task automatic send_fcs(input logic ok);
    fcs_ok = ok; fcs_in_strobe = 1'b1; step(); fcs_in_strobe = 1'b0; fcs_ok = 1'b0;
  endtask

  initial begin
    logic [47:0] ta;
    logic [47:0] held_addr;
    logic [15:0] held_dur;
    logic        stable;
    logic        seen_abort;

    //            fc        di        ra     ok   dis  elig ack  dur       m    bc
    vecs[0]  = '{16'h0008, 16'd0,    SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'd0,    1'b1, 1'b0};
    vecs[1]  = '{16'h0408, 16'd100,  SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'd56,   1'b1, 1'b0};
    vecs[2]  = '{16'h0408, 16'd30,   SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'd0,    1'b1, 1'b0};
    vecs[3]  = '{16'h0408, 16'h8005, SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'd0,    1'b1, 1'b0};
    vecs[4]  = '{16'h0408, 16'd44,   SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'd0,    1'b1, 1'b0};
    vecs[5]  = '{16'h0408, 16'd45,   SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'd1,    1'b1, 1'b0};
    vecs[6]  = '{16'h0008, 16'd100,  SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'd0,    1'b1, 1'b0};
    vecs[7]  = '{16'h0408, 16'h7FFF, SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'h7FD3, 1'b1, 1'b0};
    vecs[8]  = '{16'h0000, 16'd0,    SELF,  1'b1, 1'b0, 1'b1, 1'b1, 16'd0,    1'b1, 1'b0};
    vecs[9]  = '{16'h0008, 16'd0,    BCAST, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b1};
    vecs[10] = '{16'h0008, 16'd0,    OTHER, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0};
    vecs[11] = '{16'h00D4, 16'd0,    SELF,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};
    vecs[12] = '{16'h0004, 16'd0,    SELF,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};
    vecs[13] = '{16'h000C, 16'd0,    SELF,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};
    vecs[14] = '{16'h0008, 16'd0,    SELF,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0,    1'b1, 1'b0};
    vecs[15] = '{16'h0008, 16'd0,    SELF,  1'b1, 1'b1, 1'b0, 1'b0, 16'd0,    1'b1, 1'b0};

    ack_if.ack_ready = 1'b0;
    step();
    check("reset_outputs",
          {ack_if.ack_valid, ack_if.ack_addr, ack_if.ack_duration, addr_match, is_broadcast, ack_abort, fsm_state},
          80'd0);
    #3 rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      ta = A1 ^ 48'(i);
      ack_disable = vecs[i].dis;
      start_pkt();
      check($sformatf("v%0d_state_fc", i), 80'(fsm_state), 80'd1);
      send_fc(vecs[i].fc, vecs[i].di);
      send_ra(vecs[i].ra);
      check($sformatf("v%0d_addr_match", i), 80'(addr_match), 80'(vecs[i].exp_match));
      check($sformatf("v%0d_is_broadcast", i), 80'(is_broadcast), 80'(vecs[i].exp_bc));
      check($sformatf("v%0d_state_ra", i), 80'(fsm_state), vecs[i].exp_elig ? 80'd3 : 80'd0);
      send_ta(ta);
      check($sformatf("v%0d_no_early_valid", i), 80'(ack_if.ack_valid), 80'd0);
      send_fcs(vecs[i].ok);
      check($sformatf("v%0d_ack_valid", i), 80'(ack_if.ack_valid), 80'(vecs[i].exp_ack));
      if (vecs[i].exp_ack) begin
        check($sformatf("v%0d_ack_addr", i), 80'(ack_if.ack_addr), 80'(ta));
        check($sformatf("v%0d_ack_duration", i), 80'(ack_if.ack_duration), 80'(vecs[i].exp_dur));
      end
      ack_if.ack_ready = 1'b1; step(); ack_if.ack_ready = 1'b0;
      check($sformatf("v%0d_valid_after_ready", i), 80'(ack_if.ack_valid), 80'd0);
      check($sformatf("v%0d_state_end", i), 80'(fsm_state), 80'd0);
      ack_disable = 1'b0;
    end

    // Backpressure: request must hold steady while ack_ready stays low.
    start_pkt(); send_fc(16'h0408, 16'd100); send_ra(SELF); send_ta(A1); send_fcs(1'b1);
    held_addr = ack_if.ack_addr;
    held_dur  = ack_if.ack_duration;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (!ack_if.ack_valid || ack_if.ack_addr !== held_addr || ack_if.ack_duration !== held_dur || fsm_state !== 3'd5)
        stable = 1'b0;
    end
    check("bp_stable", 80'(stable), 80'd1);
    check("bp_addr", 80'(held_addr), 80'(A1));
    check("bp_dur", 80'(held_dur), 80'd56);
    ack_if.ack_ready = 1'b1; step(); ack_if.ack_ready = 1'b0;
    check("bp_release_valid", 80'(ack_if.ack_valid), 80'd0);
    check("bp_release_state", 80'(fsm_state), 80'd0);

    // pkt_start while the request is pending drops it.
    start_pkt(); send_fc(16'h0008, 16'd0); send_ra(SELF); send_ta(A1); send_fcs(1'b1);
    check("abort_pre_valid", 80'(ack_if.ack_valid), 80'd1);
    start_pkt();
    check("abort_pulse", 80'(ack_abort), 80'd1);
    check("abort_state", 80'(fsm_state), 80'd1);
    check("abort_valid", 80'(ack_if.ack_valid), 80'd0);
    check("abort_flag_clear", 80'(addr_match), 80'd0);
    step();
    check("abort_one_cycle", 80'(ack_abort), 80'd0);
    // Timeout out of WAIT_FC returns to IDLE silently.
    seen_abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack_abort) seen_abort = 1'b1;
    end
    check("wfc_still_waiting", 80'(fsm_state), 80'd1);
    step();
    if (ack_abort) seen_abort = 1'b1;
    check("wfc_timeout_idle", 80'(fsm_state), 80'd0);
    check("wfc_timeout_no_abort", 80'(seen_abort), 80'd0);

    // Timeout with the ACK armed in WAIT_FCS.
    start_pkt(); send_fc(16'h0008, 16'd0); send_ra(SELF); send_ta(A1);
    check("tmo_enter_fcs", 80'(fsm_state), 80'd4);
    for (int c = 0; c < 7; c++) step();
    check("tmo_cycle7_state", 80'(fsm_state), 80'd4);
    check("tmo_cycle7_no_abort", 80'(ack_abort), 80'd0);
    step();
    check("tmo_idle", 80'(fsm_state), 80'd0);
    check("tmo_abort", 80'(ack_abort), 80'd1);
    check("tmo_no_valid", 80'(ack_if.ack_valid), 80'd0);
    step();
    check("tmo_abort_clear", 80'(ack_abort), 80'd0);

    // Async reset while waiting for TA.
    start_pkt(); send_fc(16'h0008, 16'd0); send_ra(SELF);
    check("rst_pre_state", 80'(fsm_state), 80'd3);
    check("rst_pre_match", 80'(addr_match), 80'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs",
          {ack_if.ack_valid, ack_if.ack_addr, ack_if.ack_duration, addr_match, is_broadcast, ack_abort, fsm_state},
          80'd0);
    step();
    #2 rst = 1'b0;
    step();
    check("rst_after_release", 80'({ack_abort, fsm_state}), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
